// File: rtl/ack_bus_arbiter.sv
// Ack bus arbiter: round-robin ownership of a shared ack bus among four modules.
// Tracks the owner, delivers one ack per ownership and releases stalled owners.
module ack_bus_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] strobe,
    input  logic [7:0] strobe_id,
    output logic [3:0] grant,
    output logic       ack_valid,
    output logic [1:0] ack_src,
    output logic [1:0] ack_dest,
    output logic [3:0] ack_to,
    output logic       timeout_err,
    output logic       protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_OWNED     = 2'd1,
        S_BROADCAST = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(HOLD_MAX - 1);

    state_t     r_state;
    logic [3:0] r_grant;
    logic       r_ack_valid;
    logic [1:0] r_ack_src;
    logic [1:0] r_ack_dest;
    logic [3:0] r_ack_to;
    logic       r_timeout_err;
    logic       r_protocol_err;
    logic [1:0] r_ptr;
    logic [1:0] r_owner;
    logic [7:0] r_cnt;

    state_t     w_state_nxt;
    logic [3:0] w_grant_nxt;
    logic       w_ack_valid_nxt;
    logic [1:0] w_ack_src_nxt;
    logic [1:0] w_ack_dest_nxt;
    logic [3:0] w_ack_to_nxt;
    logic       w_timeout_nxt;
    logic       w_perr_nxt;
    logic [1:0] w_ptr_nxt;
    logic [1:0] w_owner_nxt;
    logic [7:0] w_cnt_nxt;

    logic [7:0] w_req2;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_win;
    logic [3:0] w_own_oh;
    logic [1:0] w_own_dest;

    // Rotate requests so bit 0 is the current round-robin head.
    assign w_req2     = {req, req};
    assign w_rot      = w_req2[r_ptr +: 4];
    assign w_win      = r_ptr + w_off;
    assign w_own_oh   = 4'b0001 << r_owner;
    assign w_own_dest = strobe_id[{r_owner, 1'b0} +: 2];

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_ack_valid_nxt = 1'b0;
        w_ack_src_nxt   = r_ack_src;
        w_ack_dest_nxt  = r_ack_dest;
        w_ack_to_nxt    = 4'b0000;
        w_timeout_nxt   = 1'b0;
        w_perr_nxt      = 1'b0;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_perr_nxt = |strobe;
                if (|req) begin
                    w_grant_nxt = 4'b0001 << w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_OWNED;
                end else begin
                    w_grant_nxt = 4'b0000;
                end
            end
            S_OWNED: begin
                w_perr_nxt = |(strobe & ~w_own_oh);
                if (|(strobe & w_own_oh)) begin
                    w_ack_valid_nxt = 1'b1;
                    w_ack_src_nxt   = r_owner;
                    w_ack_dest_nxt  = w_own_dest;
                    w_ack_to_nxt    = 4'b0001 << w_own_dest;
                    w_grant_nxt     = 4'b0000;
                    w_ptr_nxt       = r_owner + 2'd1;
                    w_state_nxt     = S_BROADCAST;
                end else if (r_cnt == LP_LAST) begin
                    w_grant_nxt   = 4'b0000;
                    w_timeout_nxt = 1'b1;
                    w_ptr_nxt     = r_owner + 2'd1;
                    w_state_nxt   = S_IDLE;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_BROADCAST: begin
                w_perr_nxt  = |strobe;
                w_grant_nxt = 4'b0000;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_grant_nxt = 4'b0000;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_grant        <= 4'b0000;
            r_ack_valid    <= 1'b0;
            r_ack_src      <= 2'd0;
            r_ack_dest     <= 2'd0;
            r_ack_to       <= 4'b0000;
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
            r_ptr          <= 2'd0;
            r_owner        <= 2'd0;
            r_cnt          <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_ack_valid    <= w_ack_valid_nxt;
            r_ack_src      <= w_ack_src_nxt;
            r_ack_dest     <= w_ack_dest_nxt;
            r_ack_to       <= w_ack_to_nxt;
            r_timeout_err  <= w_timeout_nxt;
            r_protocol_err <= w_perr_nxt;
            r_ptr          <= w_ptr_nxt;
            r_owner        <= w_owner_nxt;
            r_cnt          <= w_cnt_nxt;
        end
    end

    assign grant        = r_grant;
    assign ack_valid    = r_ack_valid;
    assign ack_src      = r_ack_src;
    assign ack_dest     = r_ack_dest;
    assign ack_to       = r_ack_to;
    assign timeout_err  = r_timeout_err;
    assign protocol_err = r_protocol_err;

endmodule
